io_port_responder: RTL and testbench

- I/O responder for the pipeline's memory stage. It services the processor's IN/OUT transactions (IOE/IOR/IOW) against an external device.
- External input samples are buffered in a small FIFO, which IN instructions pop.
- OUT instructions load a holding register that the external device drains through a valid/ack handshake.
- It asserts a stall back to the pipeline when a transaction cannot complete in the current cycle.

---
 rtl/io_port_responder.sv | 126 ++++++++++++
 tb/tb_io_port_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/io_port_responder.sv
// I/O responder for the memory stage: an input sample FIFO popped by IN, and an output holding register drained by the device.
// Optional status read-back (status_sel port) is compiled in with the IO_STATUS_EN macro.
`timescale 1ns/1ps

module io_port_responder #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             io_en,
    input  logic             io_rd,
    input  logic             io_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             io_stall,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ack
`ifdef IO_STATUS_EN
    ,
    input  logic             status_sel
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;

    logic w_rd_req;
    logic w_wr_req;
    logic w_rd_fifo;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_wr_accept;

    assign w_rd_req = io_en & io_rd & ~io_wr;
    assign w_wr_req = io_en & io_wr & ~io_rd;
    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);

`ifdef IO_STATUS_EN
    logic             w_stat_rd;
    logic [WIDTH-1:0] w_status;
    assign w_rd_fifo = w_rd_req & ~status_sel;
    assign w_stat_rd = w_rd_req & status_sel;
    always_comb begin
        w_status = '0;
        w_status[AW+3:0] = {r_count, w_full, w_empty, r_out_valid};
    end
`else
    assign w_rd_fifo = w_rd_req;
`endif

    // in_ready is purely !full, so a pop never frees a slot for a same-cycle push.
    assign w_push      = in_valid & ~w_full;
    assign w_pop       = w_rd_fifo & ~w_empty;
    assign w_wr_accept = w_wr_req & (~r_out_valid | out_ack);

    assign io_stall  = (w_rd_fifo & w_empty) | (w_wr_req & r_out_valid & ~out_ack);
    assign in_ready  = ~w_full;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr    <= r_rptr + 1'b1;
                r_rd_data <= r_mem[r_rptr];
            end
`ifdef IO_STATUS_EN
            if (w_stat_rd) begin
                r_rd_data <= w_status;
            end
            r_rd_valid <= w_pop | w_stat_rd;
`else
            r_rd_valid <= w_pop;
`endif
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_wr_accept) begin
                r_out_data  <= wr_data;
                r_out_valid <= 1'b1;
            end else if (out_ack) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_io_port_responder.sv
// Directed table-driven bench for io_port_responder: FIFO ordering/wrap, stalls, output handshake, async reset.
`timescale 1ns/1ps

module tb_io_port_responder;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             io_en;
    logic             io_rd;
    logic             io_wr;
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             io_stall;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ack;
    logic             status_sel;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    io_port_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .io_en     (io_en),
        .io_rd     (io_rd),
        .io_wr     (io_wr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .io_stall  (io_stall),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ack   (out_ack)
`ifdef IO_STATUS_EN
        ,
        .status_sel(status_sel)
`endif
    );

    // Inputs for one cycle; e_stall/e_ir are sampled before the edge, the rest after it.
    typedef struct {
        logic             en, rd, wr;
        logic [WIDTH-1:0] wdata;
        logic [WIDTH-1:0] idata;
        logic             ival, ack;
        logic             e_stall, e_ir;
        logic [WIDTH-1:0] e_rd;
        logic             e_rv;
        logic [WIDTH-1:0] e_od;
        logic             e_ov;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic en, rd, wr, input logic [WIDTH-1:0] wdata, idata,
                       input logic ival, ack, e_stall, e_ir,
                       input logic [WIDTH-1:0] e_rd, input logic e_rv,
                       input logic [WIDTH-1:0] e_od, input logic e_ov);
        vec_t v;
        v.en = en; v.rd = rd; v.wr = wr; v.wdata = wdata; v.idata = idata;
        v.ival = ival; v.ack = ack; v.e_stall = e_stall; v.e_ir = e_ir;
        v.e_rd = e_rd; v.e_rv = e_rv; v.e_od = e_od; v.e_ov = e_ov;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        io_en = 0; io_rd = 0; io_wr = 0; wr_data = '0;
        in_data = '0; in_valid = 0; out_ack = 0; status_sel = 0;
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic apply(input vec_t v, input string tag);
        io_en = v.en; io_rd = v.rd; io_wr = v.wr; wr_data = v.wdata;
        in_data = v.idata; in_valid = v.ival; out_ack = v.ack;
        #1;
        check({tag, " io_stall"}, 32'(io_stall), 32'(v.e_stall));
        check({tag, " in_ready"}, 32'(in_ready), 32'(v.e_ir));
        @(posedge clk);
        #1;
        check({tag, " rd_data"},   32'(rd_data),   32'(v.e_rd));
        check({tag, " rd_valid"},  32'(rd_valid),  32'(v.e_rv));
        check({tag, " out_data"},  32'(out_data),  32'(v.e_od));
        check({tag, " out_valid"}, 32'(out_valid), 32'(v.e_ov));
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        reset = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset rd_data",   32'(rd_data),   32'h0);
        check("reset rd_valid",  32'(rd_valid),  32'h0);
        check("reset out_data",  32'(out_data),  32'h0);
        check("reset out_valid", 32'(out_valid), 32'h0);
        check("reset in_ready",  32'(in_ready),  32'h1);
        check("reset io_stall",  32'(io_stall),  32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Push three samples then pop them back-to-back.
        add(0,0,0,16'h0,16'h1111,1,0, 0,1, 16'h0000,0,16'h0,0);
        add(0,0,0,16'h0,16'h2222,1,0, 0,1, 16'h0000,0,16'h0,0);
        add(0,0,0,16'h0,16'h3333,1,0, 0,1, 16'h0000,0,16'h0,0);
        add(1,1,0,16'h0,16'h0,0,0,    0,1, 16'h1111,1,16'h0,0);
        add(1,1,0,16'h0,16'h0,0,0,    0,1, 16'h2222,1,16'h0,0);
        add(1,1,0,16'h0,16'h0,0,0,    0,1, 16'h3333,1,16'h0,0);
        add(0,0,0,16'h0,16'h0,0,0,    0,1, 16'h3333,0,16'h0,0);
        // Fill to full (pointers wrap), blocked 5th sample, drain all five.
        add(0,0,0,16'h0,16'h0001,1,0, 0,1, 16'h3333,0,16'h0,0);
        add(0,0,0,16'h0,16'h0002,1,0, 0,1, 16'h3333,0,16'h0,0);
        add(0,0,0,16'h0,16'h0003,1,0, 0,1, 16'h3333,0,16'h0,0);
        add(0,0,0,16'h0,16'h0004,1,0, 0,1, 16'h3333,0,16'h0,0);
        add(1,1,0,16'h0,16'hAAAA,1,0, 0,0, 16'h0001,1,16'h0,0);
        add(0,0,0,16'h0,16'hAAAA,1,0, 0,1, 16'h0001,0,16'h0,0);
        add(1,1,0,16'h0,16'h0,0,0,    0,0, 16'h0002,1,16'h0,0);
        add(1,1,0,16'h0,16'h0,0,0,    0,1, 16'h0003,1,16'h0,0);
        add(1,1,0,16'h0,16'h0,0,0,    0,1, 16'h0004,1,16'h0,0);
        add(1,1,0,16'h0,16'h0,0,0,    0,1, 16'hAAAA,1,16'h0,0);
        // IN on empty stalls; push during the stalled IN is not bypassed.
        add(1,1,0,16'h0,16'h0,0,0,    1,1, 16'hAAAA,0,16'h0,0);
        add(1,1,0,16'h0,16'h00FF,1,0, 1,1, 16'hAAAA,0,16'h0,0);
        add(1,1,0,16'h0,16'h0,0,0,    0,1, 16'h00FF,1,16'h0,0);
        // OUT handshake: load, stall on busy, same-cycle drain+refill, drain, stray ack.
        add(1,0,1,16'hBEEF,16'h0,0,0, 0,1, 16'h00FF,0,16'hBEEF,1);
        add(1,0,1,16'hCAFE,16'h0,0,0, 1,1, 16'h00FF,0,16'hBEEF,1);
        add(1,0,1,16'hCAFE,16'h0,0,1, 0,1, 16'h00FF,0,16'hCAFE,1);
        add(0,0,0,16'h0,16'h0,0,1,    0,1, 16'h00FF,0,16'hCAFE,0);
        add(0,0,0,16'h0,16'h0,0,1,    0,1, 16'h00FF,0,16'hCAFE,0);
        // Malformed requests are no-ops.
        add(1,0,1,16'h1234,16'h0,0,0, 0,1, 16'h00FF,0,16'h1234,1);
        add(0,0,0,16'h0,16'h5555,1,0, 0,1, 16'h00FF,0,16'h1234,1);
        add(1,1,1,16'h9999,16'h0,0,0, 0,1, 16'h00FF,0,16'h1234,1);
        add(1,0,0,16'h9999,16'h0,0,0, 0,1, 16'h00FF,0,16'h1234,1);
        add(0,0,0,16'h0,16'h6666,1,0, 0,1, 16'h00FF,0,16'h1234,1);
        add(1,1,0,16'h0,16'h0,0,0,    0,1, 16'h5555,1,16'h1234,1);
        add(0,0,0,16'h0,16'h7777,1,0, 0,1, 16'h5555,0,16'h1234,1);

        @(negedge clk);
        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end
        drive_idle();

        // Asynchronous reset mid-cycle with 2 entries held and out_valid=1.
        #2;
        reset = 1'b0;
        #1;
        check("async rst rd_data",   32'(rd_data),   32'h0);
        check("async rst out_valid", 32'(out_valid), 32'h0);
        check("async rst out_data",  32'(out_data),  32'h0);
        check("async rst in_ready",  32'(in_ready),  32'h1);
        @(negedge clk);
        reset = 1'b1;
        v = '{en:1, rd:1, wr:0, wdata:16'h0, idata:16'h0, ival:0, ack:0,
              e_stall:1, e_ir:1, e_rd:16'h0, e_rv:0, e_od:16'h0, e_ov:0};
        apply(v, "post-rst empty IN");

`ifdef IO_STATUS_EN
        v = '{en:0, rd:0, wr:0, wdata:16'h0, idata:16'h0A0A, ival:1, ack:0,
              e_stall:0, e_ir:1, e_rd:16'h0, e_rv:0, e_od:16'h0, e_ov:0};
        apply(v, "st push0");
        v.idata = 16'h0B0B;
        apply(v, "st push1");
        status_sel = 1;
        v = '{en:1, rd:1, wr:0, wdata:16'h0, idata:16'h0, ival:0, ack:0,
              e_stall:0, e_ir:1, e_rd:16'h0010, e_rv:1, e_od:16'h0, e_ov:0};
        apply(v, "status read");
        status_sel = 0;
        v.e_rd = 16'h0A0A;
        apply(v, "st pop0");
        v.e_rd = 16'h0B0B;
        apply(v, "st pop1");
        v.e_stall = 1; v.e_rv = 0;
        apply(v, "st empty");
        drive_idle();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
